// File: rtl/drd_alu_pkg.sv
// -----------------------------------------------------------------------------
// drd_alu_pkg
// Shared definitions for the ALU operation sequencer:
//   - 3-bit operation class codes (ocode[6:4])
//   - unit indices, shared by the one-hot unit enable and result-mux select
//   - sequencer FSM state encoding
// Optional feature macro used by the importing files: DRD_ALU_MAC_EN.
// -----------------------------------------------------------------------------
package drd_alu_pkg;

  localparam logic [2:0] CLS_ADDSUB = 3'd0;
  localparam logic [2:0] CLS_LOGIC  = 3'd1;
  localparam logic [2:0] CLS_SHIFT  = 3'd2;
  localparam logic [2:0] CLS_COM    = 3'd3;
  localparam logic [2:0] CLS_MUL    = 3'd4;
  localparam logic [2:0] CLS_MAC    = 3'd5;

  localparam int UNIT_ADDSUB = 0;
  localparam int UNIT_LOGIC  = 1;
  localparam int UNIT_SHIFT  = 2;
  localparam int UNIT_COM    = 3;
  localparam int UNIT_MUL    = 4;
  localparam int UNIT_MAC    = 5;
  localparam int UNIT_N      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/drd_alu_cls_dec.sv
// -----------------------------------------------------------------------------
// drd_alu_cls_dec
// Purely combinational class decoder: maps the 3-bit operation class to a
// one-hot unit enable and flags unsupported classes.
// Macro DRD_ALU_MAC_EN: when defined, class 101 decodes to the MAC unit;
// otherwise class 101 is flagged illegal and the MAC bit is never set.
// Ports:
//   cls      in  3  operation class
//   en       out 6  one-hot unit enable (bit order per drd_alu_pkg UNIT_*)
//   illegal  out 1  class not supported by this build
// -----------------------------------------------------------------------------
module drd_alu_cls_dec
  import drd_alu_pkg::*;
(
  input  logic [2:0]        cls,
  output logic [UNIT_N-1:0] en,
  output logic              illegal
);

  // class -> one-hot enable / illegal flag
  always_comb begin
    en      = 6'b000000;
    illegal = 1'b0;
    case (cls)
      CLS_ADDSUB: en[UNIT_ADDSUB] = 1'b1;
      CLS_LOGIC:  en[UNIT_LOGIC]  = 1'b1;
      CLS_SHIFT:  en[UNIT_SHIFT]  = 1'b1;
      CLS_COM:    en[UNIT_COM]    = 1'b1;
      CLS_MUL:    en[UNIT_MUL]    = 1'b1;
`ifdef DRD_ALU_MAC_EN
      CLS_MAC:    en[UNIT_MAC]    = 1'b1;
`else
      CLS_MAC:    illegal         = 1'b1;
`endif
      default:    illegal         = 1'b1;
    endcase
  end

endmodule

// File: rtl/drd_alu_seq.sv
// -----------------------------------------------------------------------------
// drd_alu_seq
// Operation sequencer for a small ALU datapath. Accepts an opcode in IDLE,
// drives the one-hot unit enable for one cycle (single-cycle classes) or for
// MUL_CYCLES / MUL_CYCLES+1 cycles (MUL / MAC), pulses the result-register
// capture enable on the last execute cycle, then holds the result valid until
// the consumer takes it.
// Every operation starts with one decode cycle (counter value 0) in which the
// result-mux select is already set but no unit is enabled; this gives a
// result-valid latency of 2 cycles for single-cycle classes and MUL_CYCLES+1
// for MUL.
// Macro DRD_ALU_MAC_EN: compiles the MAC (class 101) path in; otherwise 101 is
// illegal and bit 5 of unit_en_o / sel_o is never set.
// Ports:
//   CLK          in   1  clock, rising edge
//   RST          in   1  synchronous active-high reset
//   op_valid_i   in   1  opcode request valid
//   op_ready_o   out  1  sequencer idle, can accept an opcode
//   ocode_i      in   7  [6:4] class, [0] MUL high/low half select
//   unit_en_o    out  6  one-hot unit enable
//   sel_o        out  6  one-hot result-mux select
//   sel_n_o      out  6  rail complement of sel_o
//   mul_hi_o     out  1  high product half select
//   reg_en_o     out  1  result register capture enable
//   res_valid_o  out  1  result register holds a valid result
//   res_ready_i  in   1  consumer accepts the result
//   illegal_o    out  1  one-cycle pulse for an unsupported class
//   busy_o       out  1  sequencer not idle
// -----------------------------------------------------------------------------
module drd_alu_seq
  import drd_alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [6:0]        ocode_i,
  output logic [UNIT_N-1:0] unit_en_o,
  output logic [UNIT_N-1:0] sel_o,
  output logic [UNIT_N-1:0] sel_n_o,
  output logic              mul_hi_o,
  output logic              reg_en_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              illegal_o,
  output logic              busy_o
);

  // counter value of the final execute cycle per class group
  localparam logic [CNT_W-1:0] ONE_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [CNT_W-1:0]    last_r, last_next_s;
  logic [UNIT_N-1:0]   sel_r, sel_next_s;
  logic                mul_hi_r, mul_hi_next_s;
  logic                illegal_next_s;
  logic [UNIT_N-1:0]   dec_en_s;
  logic                dec_illegal_s;
  logic                active_next_s;
  logic [UNIT_N-1:0]   unit_en_r;
  logic                reg_en_r, res_valid_r, illegal_r, ready_r, busy_r;
  logic                ocode_unused_s;

  // only the class field and the half-select bit carry meaning
  assign ocode_unused_s = ^ocode_i[3:1];

  drd_alu_cls_dec u_cls_dec (
    .cls     (ocode_i[6:4]),
    .en      (dec_en_s),
    .illegal (dec_illegal_s)
  );

  // next-state, counter and latched-operand logic
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    last_next_s    = last_r;
    sel_next_s     = sel_r;
    mul_hi_next_s  = mul_hi_r;
    illegal_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (op_valid_i) begin
          if (dec_illegal_s) begin
            // accepted but dropped: stay idle, only flag it
            illegal_next_s = 1'b1;
          end else begin
            sel_next_s    = dec_en_s;
            mul_hi_next_s = ocode_i[0];
            if (dec_en_s[UNIT_MUL]) begin
              state_next_s = ST_MULW;
              last_next_s  = MUL_LAST;
            end else if (dec_en_s[UNIT_MAC]) begin
              state_next_s = ST_MULW;
              last_next_s  = MAC_LAST;
            end else begin
              state_next_s = ST_EXEC;
              last_next_s  = ONE_LAST;
            end
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC, ST_MULW: begin
        if (cnt_r == last_r) begin
          state_next_s = ST_HOLD;
        end else begin
          cnt_next_s = cnt_r + ONE_LAST;
        end
      end
      ST_HOLD: begin
        if (res_ready_i) begin
          state_next_s  = ST_IDLE;
          cnt_next_s    = CNT_ZERO;
          sel_next_s    = 6'b000000;
          mul_hi_next_s = 1'b0;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        cnt_next_s    = CNT_ZERO;
        sel_next_s    = 6'b000000;
        mul_hi_next_s = 1'b0;
      end
    endcase
  end

  // execute window: past the decode cycle of EXEC/MULW
  always_comb begin
    active_next_s = 1'b0;
    if ((state_next_s == ST_EXEC) || (state_next_s == ST_MULW)) begin
      active_next_s = (cnt_next_s != CNT_ZERO);
    end else begin
      active_next_s = 1'b0;
    end
  end

  // state and registered outputs, all derived from next-state values
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      last_r      <= CNT_ZERO;
      sel_r       <= 6'b000000;
      mul_hi_r    <= 1'b0;
      illegal_r   <= 1'b0;
      unit_en_r   <= 6'b000000;
      reg_en_r    <= 1'b0;
      res_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      last_r      <= last_next_s;
      sel_r       <= sel_next_s;
      mul_hi_r    <= mul_hi_next_s;
      illegal_r   <= illegal_next_s;
      unit_en_r   <= active_next_s ? sel_next_s : 6'b000000;
      reg_en_r    <= active_next_s && (cnt_next_s == last_next_s);
      res_valid_r <= (state_next_s == ST_HOLD);
      ready_r     <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign op_ready_o  = ready_r;
  assign busy_o      = busy_r;
  assign unit_en_o   = unit_en_r;
  assign sel_o       = sel_r;
  assign sel_n_o     = ~sel_r;
  assign mul_hi_o    = mul_hi_r;
  assign reg_en_o    = reg_en_r;
  assign res_valid_o = res_valid_r;
  assign illegal_o   = illegal_r;

endmodule

// File: tb/tb_drd_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_drd_alu_seq
// Self-checking bench for drd_alu_seq. A timeline model derives, for an opcode
// accepted at some edge, the expected output vector k cycles later from the
// class rules (execute length, one-hot unit, result latency).
// Honours DRD_ALU_MAC_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_drd_alu_seq;

  localparam int MULC = 4;
`ifdef DRD_ALU_MAC_EN
  localparam bit MAC_ON = 1'b1;
`else
  localparam bit MAC_ON = 1'b0;
`endif

  // {ready, busy, unit_en, sel, sel_n, mul_hi, reg_en, res_valid, illegal}
  localparam logic [23:0] IDLE_V = {1'b1, 1'b0, 6'h00, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       op_valid_i = 1'b0;
  logic       op_ready_o;
  logic [6:0] ocode_i = 7'h00;
  logic [5:0] unit_en_o, sel_o, sel_n_o;
  logic       mul_hi_o, reg_en_o, res_valid_o;
  logic       res_ready_i = 1'b0;
  logic       illegal_o, busy_o;
  logic [23:0] obs;

  int checks = 0;
  int errors = 0;

  drd_alu_seq #(.MUL_CYCLES(MULC), .CNT_W(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .ocode_i     (ocode_i),
    .unit_en_o   (unit_en_o),
    .sel_o       (sel_o),
    .sel_n_o     (sel_n_o),
    .mul_hi_o    (mul_hi_o),
    .reg_en_o    (reg_en_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .illegal_o   (illegal_o),
    .busy_o      (busy_o)
  );

  always #5 CLK = ~CLK;

  assign obs = {op_ready_o, busy_o, unit_en_o, sel_o, sel_n_o,
                mul_hi_o, reg_en_o, res_valid_o, illegal_o};

  function automatic bit is_illegal(input logic [6:0] oc);
    return (oc[6:4] > 3'd5) || ((oc[6:4] == 3'd5) && !MAC_ON);
  endfunction

  function automatic int exec_len(input logic [6:0] oc);
    if (oc[6:4] < 3'd4)       return 1;
    else if (oc[6:4] == 3'd4) return MULC;
    else                      return MULC + 1;
  endfunction

  // expected outputs k cycles after the accept edge, result not yet taken
  function automatic logic [23:0] model(input logic [6:0] oc, input int k);
    logic [5:0] oh;
    int len;
    if (is_illegal(oc)) return (k == 0) ? (IDLE_V | 24'h000001) : IDLE_V;
    len = exec_len(oc);
    oh  = 6'b000001 << oc[6:4];
    return {1'b0, 1'b1, ((k >= 1) && (k <= len)) ? oh : 6'h00, oh, ~oh,
            oc[0], (k == len), (k > len), 1'b0};
  endfunction

  // one complete operation: accept, follow the timeline, release after
  // 'hold' extra HOLD cycles; op_valid/ocode are scrambled while busy
  task automatic run_op(input logic [6:0] oc, input int hold, input bit keep_valid,
                        input string name);
    int len;
    bit ill;
    logic [23:0] exp;
    len = exec_len(oc);
    ill = is_illegal(oc);
    op_valid_i  = 1'b1;
    ocode_i     = oc;
    res_ready_i = 1'($urandom);
    @(posedge CLK); #1;
    for (int k = 0; k <= len + 1 + hold; k++) begin
      exp = model(oc, k);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s oc=%h k=%0d outputs=%h expected=%h", name, oc, k, obs, exp);
      end
      checks++;
      if ((reg_en_o & res_valid_o) !== 1'b0) begin
        errors++;
        $display("FAIL %s_regen_valid_overlap k=%0d got=%b expected=0", name, k,
                 reg_en_o & res_valid_o);
      end
      if (ill) begin
        op_valid_i = 1'b0;
        break;
      end
      if (k == len + 1 + hold) begin
        res_ready_i = 1'b1;
        op_valid_i  = keep_valid ? 1'b1 : 1'($urandom);
        break;
      end
      res_ready_i = (k <= len) ? 1'($urandom) : 1'b0;
      op_valid_i  = keep_valid ? 1'b1 : 1'($urandom);
      ocode_i     = 7'($urandom);
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL %s_return_idle oc=%h outputs=%h expected=%h", name, oc, obs, IDLE_V);
    end
    op_valid_i  = 1'b0;
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    op_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ocode_i = 7'($urandom);
      @(posedge CLK); #1;
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL reset_values cycle=%0d outputs=%h expected=%h", i, obs, IDLE_V);
      end
    end
    op_valid_i = 1'b0;
    RST        = 1'b0;
  endtask

  task automatic test_single_cycle();
    run_op(7'h10, 0, 1'b0, "logic");
    run_op(7'h01, 2, 1'b0, "addsub");
    run_op(7'h2F, 1, 1'b0, "shift");
    run_op(7'h33, 0, 1'b0, "com");
  endtask

  task automatic test_mul();
    run_op(7'h41, 0, 1'b0, "mul_hi");
    run_op(7'h40, 3, 1'b0, "mul_lo");
  endtask

  task automatic test_hold();
    run_op(7'h22, 10, 1'b1, "hold_backpressure");
  endtask

  task automatic test_illegal();
    run_op(7'h60, 0, 1'b0, "illegal_110");
    run_op(7'h7F, 0, 1'b0, "illegal_111");
  endtask

  task automatic test_mac();
    run_op(7'h50, 2, 1'b0, "mac_class");
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp;
    op_valid_i = 1'b1;
    ocode_i    = 7'h41;
    @(posedge CLK); #1;
    op_valid_i = 1'b0;
    @(posedge CLK); #1;
    exp = model(7'h41, 1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_mid_pre outputs=%h expected=%h", obs, exp);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_mid_values outputs=%h expected=%h", obs, IDLE_V);
    end
    for (int i = 0; i < 8; i++) begin
      res_ready_i = 1'($urandom);
      @(posedge CLK); #1;
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL reset_mid_abandon cycle=%0d outputs=%h expected=%h", i, obs, IDLE_V);
      end
    end
    res_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(7'h12, 0, 1'b0, "b2b_0");
    run_op(7'h41, 0, 1'b0, "b2b_1");
    run_op(7'h60, 0, 1'b0, "b2b_2");
    run_op(7'h30, 0, 1'b0, "b2b_3");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_op(7'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_hold();
    test_illegal();
    test_mac();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/drd_alu_seq.md
DRD_ALU_SEQ -- requirements
Module: drd_alu_seq

Interface
REQ-001 Parameter MUL_CYCLES, default 4: number of EXEC-phase cycles for a MUL operation (legal range 2..15).
REQ-002 Parameter CNT_W, default 4: width of the internal cycle counter (must hold MUL_CYCLES+1).
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 op_valid_i  in  1  opcode request valid.
REQ-007 op_ready_o  out  1  sequencer can accept an opcode.
REQ-008 ocode_i  in  7  operation code; class = ocode_i[6:4], ocode_i[0] = MUL high/low half select.
REQ-009 unit_en_o  out  6  one-hot unit enable: bit0 ADDSUB, bit1 LOGIC, bit2 SHIFT, bit3 COM, bit4 MUL, bit5 MAC.
REQ-010 sel_o  out  6  one-hot result-mux select, with the same bit order as unit_en_o.
REQ-011 sel_n_o  out  6  rail complement of sel_o.
REQ-012 mul_hi_o  out  1  selects the high product half (1) or the low half (0).
REQ-013 reg_en_o  out  1  result register capture enable.
REQ-014 res_valid_o  out  1  result register holds a valid result.
REQ-015 res_ready_i  in  1  consumer accepts the result.
REQ-016 illegal_o  out  1  one-cycle pulse flagging an unsupported class.
REQ-017 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, EXEC, MULW, HOLD.
REQ-019 op_ready_o SHALL be 1 only in IDLE; an opcode is accepted when op_valid_i and op_ready_o are both 1.
REQ-020 Class decode SHALL be: 000 ADDSUB, 001 LOGIC, 010 SHIFT, 011 COM, 100 MUL, 101 MAC; classes 110 and 111 are illegal.
REQ-021 An accepted single-cycle class (000..011) SHALL move IDLE->EXEC; in EXEC the unit's bit of unit_en_o and reg_en_o are 1 for exactly one cycle; the FSM then moves to HOLD.
REQ-022 An accepted MUL SHALL move IDLE->MULW.
REQ-023 In MULW, unit_en_o[4] SHALL stay 1 for MUL_CYCLES cycles, with reg_en_o=1 only on the final cycle; the FSM then moves to HOLD.
REQ-024 mul_hi_o SHALL be latched from ocode_i[0] at accept and held until the FSM returns to IDLE.
REQ-025 In HOLD, res_valid_o SHALL be 1 and unit_en_o SHALL be 0.
REQ-026 HOLD->IDLE SHALL occur on the cycle in which res_ready_i=1; otherwise the FSM stays in HOLD indefinitely.
REQ-027 Latency: for an opcode accepted at edge N, res_valid_o SHALL rise at N+2 for single-cycle classes and at N+1+MUL_CYCLES for MUL.
REQ-028 sel_o SHALL be latched at accept, held stable through EXEC/MULW/HOLD, and be all-zero in IDLE.
REQ-029 sel_n_o SHALL equal ~sel_o in every cycle, including during reset.
REQ-030 An illegal class SHALL be accepted, SHALL pulse illegal_o for one cycle after accept, and SHALL leave the FSM in IDLE with no reg_en_o and no res_valid_o.
REQ-031 op_valid_i SHALL be ignored outside IDLE, so no opcode overlaps another.
REQ-032 reg_en_o and res_valid_o SHALL never both be 1 in the same cycle.

Reset
REQ-033 While RST=1 on a rising edge, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-034 The reset values SHALL be: unit_en_o=0, sel_o=0, sel_n_o=6'h3F, mul_hi_o=0, reg_en_o=0, res_valid_o=0, illegal_o=0, busy_o=0.
REQ-035 After reset, op_ready_o SHALL be 1.
REQ-036 A reset asserted mid-operation (EXEC, MULW or HOLD) SHALL abandon the operation with no further reg_en_o and no res_valid_o.

Configuration
REQ-037 Macro DRD_ALU_MAC_EN compiles the MAC path in or out.
REQ-038 With DRD_ALU_MAC_EN defined, class 101 SHALL follow the MULW path with unit_en_o[5]=1 for MUL_CYCLES+1 cycles, and reg_en_o=1 on the final cycle.
REQ-039 Without DRD_ALU_MAC_EN, class 101 SHALL be treated as illegal, and unit_en_o[5] and sel_o[5] SHALL be tied to 0.

Structure
REQ-040 A shared package drd_alu_pkg SHALL hold: the class-code constants, the unit-index constants (0..5), and the FSM state enum.
REQ-041 One sub-module, drd_alu_cls_dec, SHALL map the 3-bit class to a one-hot enable plus an illegal flag; it is purely combinational.

Verification
REQ-042 Reset, then ocode=7'h10 (LOGIC) accepted at edge 0 -> unit_en_o=6'b000010 and reg_en_o=1 in cycle 1; res_valid_o=1 from cycle 2; sel_o=6'b000010 and sel_n_o=6'b111101 throughout.
REQ-043 ocode=7'h41 (MUL hi) with MUL_CYCLES=4 -> unit_en_o[4]=1 for 4 cycles, reg_en_o only on the 4th, mul_hi_o=1, res_valid_o at N+5.
REQ-044 Result pending with res_ready_i=0 for 10 cycles, op_valid_i held at 1 -> op_ready_o=0, res_valid_o held, sel_o stable; on res_ready_i=1 -> IDLE the next cycle.
REQ-045 ocode=7'h60 -> illegal_o pulse of exactly 1 cycle, no res_valid_o, op_ready_o=1 the next cycle; ocode=7'h50 -> illegal_o pulse without DRD_ALU_MAC_EN, and a 5-cycle MAC execution with it.
REQ-046 RST=1 in the 2nd MULW cycle -> next cycle all outputs at their reset values, and no res_valid_o afterwards.
